// File: rtl/inst_fetch_queue.sv
// Instruction fetch with a small prefetch queue feeding the IF/ID register.
// Fetches over a single-outstanding req/ack port and discards data from transfers cut off by a branch.
module inst_fetch_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'hF000_0000,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_freeze,
   input  logic                       i_branch_taken,
   input  logic [31:0]                i_branch_addr,
   output logic                       o_imem_req,
   output logic [31:0]                o_imem_addr,
   input  logic                       i_imem_ack,
   input  logic [31:0]                i_imem_rdata,
   output logic [31:0]                o_instruction_ID,
   output logic [31:0]                o_pc_ID,
   output logic [$clog2(DEPTH):0]     o_queue_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   r_q_instr [DEPTH];
   logic [31:0]   r_q_pc    [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_req_addr;
   logic          r_req;
   logic          r_stale;
   logic [31:0]   r_instr_id;
   logic [31:0]   r_pc_id;

   logic          w_acc;
   logic          w_held;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_next;
   logic [31:0]   w_fetch_pc_next;

   always_comb begin
      w_acc  = r_req & i_imem_ack;
      w_held = r_req & ~i_imem_ack;
      w_push = w_acc & ~r_stale & ~i_branch_taken;
      w_pop  = ~i_branch_taken & ~i_freeze & (r_count != '0);
      w_count_next = '0;
      if (!i_branch_taken)
         w_count_next = r_count + CW'(w_push) - CW'(w_pop);
      w_fetch_pc_next = r_fetch_pc;
      if (i_branch_taken)
         w_fetch_pc_next = i_branch_addr;
      else if (w_acc && !r_stale)
         w_fetch_pc_next = r_fetch_pc + 32'd4;
   end

   // Queue storage carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_q_instr[r_tail] <= i_imem_rdata;
         r_q_pc[r_tail]    <= r_req_addr + 32'd4;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_req      <= 1'b0;
         r_stale    <= 1'b0;
         r_instr_id <= NOP_INSTR;
         r_pc_id    <= '0;
      end else begin
         r_fetch_pc <= w_fetch_pc_next;
         r_count    <= w_count_next;
         if (i_branch_taken) begin
            r_head <= '0;
            r_tail <= '0;
         end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
         end
         // A cut-off transfer keeps its address until acked; its data is then dropped.
         if (i_branch_taken)
            r_stale <= w_held;
         else if (w_acc)
            r_stale <= 1'b0;
         if (!w_held) begin
            r_req      <= (w_count_next < CW'(DEPTH));
            r_req_addr <= w_fetch_pc_next;
         end
         if (i_branch_taken) begin
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= '0;
         end else if (!i_freeze) begin
            if (r_count != '0) begin
               r_instr_id <= r_q_instr[r_head];
               r_pc_id    <= r_q_pc[r_head];
            end else begin
               r_instr_id <= NOP_INSTR;
               r_pc_id    <= '0;
            end
         end
      end
   end

   assign o_imem_req       = r_req;
   assign o_imem_addr      = r_req_addr;
   assign o_instruction_ID = r_instr_id;
   assign o_pc_ID          = r_pc_id;
   assign o_queue_count    = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: variable-latency memory model plus a scoreboard of fetched words
// that is checked against IF/ID, queue occupancy and the request port every cycle.
module tb_inst_fetch_queue;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'hF000_0000;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruction_ID;
   logic [31:0] pc_ID;
   logic [2:0]  queue_count;

   int errors = 0;
   int checks = 0;

   inst_fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .RESET_PC(32'h0)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_freeze         (freeze),
      .i_branch_taken   (branch_taken),
      .i_branch_addr    (branch_addr),
      .o_imem_req       (imem_req),
      .o_imem_addr      (imem_addr),
      .i_imem_ack       (imem_ack),
      .i_imem_rdata     (imem_rdata),
      .o_instruction_ID (instruction_ID),
      .o_pc_ID          (pc_ID),
      .o_queue_count    (queue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: ack once req has been high for lat cycles (lat=0 acks immediately).
   int lat = 1;
   bit ack_en = 1'b1;
   int wait_cnt = 0;
   assign imem_ack   = imem_req && ack_en && (wait_cnt >= lat);
   assign imem_rdata = imem_addr | 32'hE000_0000;
   always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard and reference state, advanced once per edge from the pre-edge snapshot.
   logic [63:0] sb[$];
   logic [31:0] m_instr = NOP, m_pc = 0, m_fpc = 0;
   bit          m_stale = 0;
   bit          s_valid = 0, s_rst, s_br, s_fr, s_req, s_ack;
   logic [31:0] s_baddr, s_addr, s_rdata;

   always @(negedge clk) begin
      bit held, acc;
      logic [63:0] e;
      if (s_valid) begin
         held = s_req && !s_ack && !s_rst;
         acc  = s_req && s_ack;
         if (s_rst) begin
            sb.delete();
            m_instr = NOP; m_pc = 0; m_fpc = 0; m_stale = 0;
         end else begin
            if (s_br) begin
               m_instr = NOP; m_pc = 0; sb.delete();
            end else if (!s_fr) begin
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  m_instr = e[63:32]; m_pc = e[31:0];
               end else begin
                  m_instr = NOP; m_pc = 0;
               end
            end
            if (acc && !m_stale && !s_br) sb.push_back({s_rdata, s_addr + 32'd4});
            if (s_br) m_fpc = s_baddr;
            else if (acc && !m_stale) m_fpc = m_fpc + 32'd4;
            if (s_br) m_stale = s_req && !s_ack;
            else if (acc) m_stale = 0;
         end
         chk("instr_id", instruction_ID, m_instr);
         chk("pc_id", pc_ID, m_pc);
         chk("queue_count", 32'(queue_count), 32'(sb.size()));
         chk("imem_req", 32'(imem_req), (!s_rst && (held || sb.size() < DEPTH)) ? 32'd1 : 32'd0);
         chk("imem_addr", imem_addr, held ? s_addr : m_fpc);
      end
      s_valid = 1; s_rst = rst; s_br = branch_taken; s_fr = freeze; s_baddr = branch_addr;
      s_req = imem_req; s_ack = imem_ack; s_addr = imem_addr; s_rdata = imem_rdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
      repeat (3) tick();
      chk("rst_instr", instruction_ID, NOP);
      chk("rst_count", 32'(queue_count), 32'd0);
      rst = 1'b0;

      // Streaming with one-cycle memory latency.
      n = 0;
      while (instruction_ID == NOP && n < 30) begin tick(); n++; end
      chk("first_instr", instruction_ID, 32'hE000_0000);
      chk("first_pc", pc_ID, 32'd4);
      repeat (12) tick();

      // Freeze with an immediate-ack memory fills the queue, then drains.
      lat = 0;
      freeze = 1'b1;
      repeat (6) tick();
      chk("frz_full", 32'(queue_count), 32'd4);
      chk("frz_noreq", 32'(imem_req), 32'd0);
      freeze = 1'b0;
      repeat (8) tick();

      // Branch with three entries buffered.
      freeze = 1'b1;
      n = 0;
      while (queue_count != 3'd3 && n < 10) begin tick(); n++; end
      chk("br3_fill", 32'(queue_count), 32'd3);
      freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
      tick();
      branch_taken = 1'b0;
      chk("br3_instr", instruction_ID, NOP);
      chk("br3_count", 32'(queue_count), 32'd0);
      chk("br3_addr", imem_addr, 32'h100);
      n = 0;
      while (pc_ID == 0 && n < 10) begin tick(); n++; end
      chk("br3_pc", pc_ID, 32'h104);
      repeat (4) tick();

      // Branch while a request to 0x20 is outstanding with 3-cycle latency.
      lat = 3;
      branch_taken = 1'b1; branch_addr = 32'h20;
      tick();
      branch_taken = 1'b0;
      n = 0;
      while (!(imem_req && imem_addr == 32'h20) && n < 20) begin tick(); n++; end
      chk("stale_seen", 32'(imem_req && imem_addr == 32'h20), 32'd1);
      branch_taken = 1'b1; branch_addr = 32'h200;
      tick();
      branch_taken = 1'b0;
      chk("stale_hold", imem_addr, 32'h20);
      n = 0;
      while (imem_addr == 32'h20 && n < 10) begin tick(); n++; end
      chk("stale_next", imem_addr, 32'h200);
      repeat (15) tick();

      // Branch and freeze together: branch wins.
      lat = 0;
      freeze = 1'b1;
      repeat (3) tick();
      branch_taken = 1'b1; branch_addr = 32'h300;
      tick();
      branch_taken = 1'b0; freeze = 1'b0;
      chk("brfrz_instr", instruction_ID, NOP);
      chk("brfrz_count", 32'(queue_count), 32'd0);
      repeat (6) tick();

      // Reset during an unacked request.
      ack_en = 1'b0;
      n = 0;
      while (!imem_req && n < 10) begin tick(); n++; end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_req", 32'(imem_req), 32'd0);
      chk("rstmid_count", 32'(queue_count), 32'd0);
      chk("rstmid_instr", instruction_ID, NOP);
      chk("rstmid_addr", imem_addr, 32'h0);
      ack_en = 1'b1; lat = 1;
      n = 0;
      while (instruction_ID == NOP && n < 30) begin tick(); n++; end
      chk("rstmid_first", instruction_ID, 32'hE000_0000);
      chk("rstmid_pc", pc_ID, 32'd4);
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
